// File: rtl/stream_mux_pkg.sv
// Shared encodings for the stream mux: mode select values and output-register states.
package stream_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);
  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      // ptr is always < NUM_CH, so one subtraction is enough to wrap
      c = int'(ptr) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = SEL_W'(c);
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream mux with fixed or round-robin selection into a one-entry output register.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH  = 2,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MODE,
  input  logic [SEL_W-1:0]        SEL,
  input  logic [NUM_CH*WIDTH-1:0] IN_DATA,
  input  logic [NUM_CH-1:0]       IN_VALID,
  output logic [NUM_CH-1:0]       IN_READY,
  output logic [WIDTH-1:0]        X,
  output logic                    X_VALID,
  input  logic                    X_READY,
  output logic [SEL_W-1:0]        X_CH
);
  state_t              state;
  logic [SEL_W-1:0]    ptr;
  logic                load_en;
  logic                sel_ok;
  logic                grant;
  logic [NUM_CH-1:0]   gnt;
  logic [SEL_W-1:0]    gnt_idx;
  logic [NUM_CH-1:0]   arb_gnt;
  logic [SEL_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
    .req (IN_VALID),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign load_en = (state == ST_EMPTY) || X_READY;
  assign sel_ok  = int'(SEL) < NUM_CH;

  always_comb begin
    gnt     = '0;
    gnt_idx = SEL;
    grant   = 1'b0;
    if (!RST && load_en) begin
      if (MODE == MODE_RR) begin
        if (arb_any) begin
          gnt     = arb_gnt;
          gnt_idx = arb_idx;
          grant   = 1'b1;
        end
      end else if (sel_ok && IN_VALID[SEL]) begin
        gnt[SEL] = 1'b1;
        grant    = 1'b1;
      end
    end
  end

  assign IN_READY = gnt;
  assign X_VALID  = (state == ST_FULL);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_EMPTY;
      X     <= '0;
      X_CH  <= '0;
      ptr   <= '0;
    end else if (grant) begin
      state <= ST_FULL;
      X     <= IN_DATA[gnt_idx*WIDTH +: WIDTH];
      X_CH  <= gnt_idx;
      if (MODE == MODE_RR) begin
        if (int'(gnt_idx) == NUM_CH - 1) ptr <= '0;
        else                             ptr <= gnt_idx + 1'b1;
      end
    end else if (X_READY) begin
      state <= ST_EMPTY;
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench: default 4x2 mux plus a 3-channel 8-bit instance for wrap and out-of-range select.
module tb_stream_mux_rr;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic       mode0, xr0, xv0;
  logic [1:0] sel0, x0, xch0;
  logic [7:0] din0;
  logic [3:0] iv0, ir0;

  logic        mode1, xr1, xv1;
  logic [1:0]  sel1, xch1;
  logic [23:0] din1;
  logic [2:0]  iv1, ir1;
  logic [7:0]  x1;

  int n_chk = 0;
  int n_fail = 0;

  stream_mux_rr u0 (
    .CLK(CLK), .RST(RST), .MODE(mode0), .SEL(sel0), .IN_DATA(din0),
    .IN_VALID(iv0), .IN_READY(ir0), .X(x0), .X_VALID(xv0), .X_READY(xr0), .X_CH(xch0)
  );

  stream_mux_rr #(.WIDTH(8), .NUM_CH(3)) u1 (
    .CLK(CLK), .RST(RST), .MODE(mode1), .SEL(sel1), .IN_DATA(din1),
    .IN_VALID(iv1), .IN_READY(ir1), .X(x1), .X_VALID(xv1), .X_READY(xr1), .X_CH(xch1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk0(input string tag, input logic v, input logic [1:0] ch, input logic [1:0] d);
    chk({tag, "_valid"}, 32'(xv0), 32'(v));
    chk({tag, "_ch"},    32'(xch0), 32'(ch));
    chk({tag, "_x"},     32'(x0), 32'(d));
  endtask

  initial begin
    RST = 1'b1; mode0 = 1'b0; sel0 = 2'd0; xr0 = 1'b1;
    din0 = 8'b11_00_01_10;   // ch3=11 ch2=00 ch1=01 ch0=10
    iv0 = 4'b1111;
    mode1 = 1'b1; sel1 = 2'd0; xr1 = 1'b1; iv1 = 3'b000;
    din1 = {8'hC2, 8'hB1, 8'hA0};
    #1;
    chk("rst_inready", 32'(ir0), 32'h0);
    step();
    step();
    chk0("reset", 1'b0, 2'd0, 2'd0);
    chk("rst_inready_hold", 32'(ir0), 32'h0);
    chk("u1_reset_valid", 32'(xv1), 32'h0);

    // fixed mode, SEL stepped 0..3
    RST = 1'b0;
    #1;
    chk("fix_inready0", 32'(ir0), 32'b0001);
    step(); chk0("fix0", 1'b1, 2'd0, 2'b10);
    sel0 = 2'd1; step(); chk0("fix1", 1'b1, 2'd1, 2'b01);
    sel0 = 2'd2; #1; chk("fix_inready2", 32'(ir0), 32'b0100);
    step(); chk0("fix2", 1'b1, 2'd2, 2'b00);
    sel0 = 2'd3; step(); chk0("fix3", 1'b1, 2'd3, 2'b11);

    // round-robin, all valid: ptr still 0 since fixed grants leave it alone
    mode0 = 1'b1;
    #1; chk("rr_inready0", 32'(ir0), 32'b0001);
    step(); chk0("rr0", 1'b1, 2'd0, 2'b10);
    #1; chk("rr_inready1", 32'(ir0), 32'b0010);
    step(); chk0("rr1", 1'b1, 2'd1, 2'b01);
    step(); chk0("rr2", 1'b1, 2'd2, 2'b00);
    step(); chk0("rr3", 1'b1, 2'd3, 2'b11);
    step(); chk0("rr4", 1'b1, 2'd0, 2'b10);

    // backpressure: held beat ch0, ptr=1
    xr0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("bp_inready", 32'(ir0), 32'h0);
      sel0 = 2'(i); mode0 = i[0];   // select/mode churn must not disturb the held beat
      step(); chk0("bp_hold", 1'b1, 2'd0, 2'b10);
    end
    mode0 = 1'b1;
    xr0 = 1'b1;
    #1; chk("bp_release_inready", 32'(ir0), 32'b0010);
    step(); chk0("bp_next", 1'b1, 2'd1, 2'b01);

    // sparse: only ch1 and ch3, ptr=2
    iv0 = 4'b1010;
    step(); chk0("sp0", 1'b1, 2'd3, 2'b11);
    step(); chk0("sp1", 1'b1, 2'd1, 2'b01);
    step(); chk0("sp2", 1'b1, 2'd3, 2'b11);
    step(); chk0("sp3", 1'b1, 2'd1, 2'b01);

    // reset while FULL; ptr was 2, must restart at 0 so ch1 wins over ch3
    RST = 1'b1;
    #1; chk("rstfull_inready", 32'(ir0), 32'h0);
    step(); chk0("rstfull", 1'b0, 2'd0, 2'd0);
    RST = 1'b0;
    #1; chk("post_rst_inready", 32'(ir0), 32'b0010);
    step(); chk0("post_rst", 1'b1, 2'd1, 2'b01);

    // drain with nothing valid: EMPTY, data holds
    iv0 = 4'b0000;
    step(); chk0("drain", 1'b0, 2'd1, 2'b01);

    // NUM_CH=3, WIDTH=8 round-robin wrap 2->0
    iv1 = 3'b111;
    step(); chk("u1_rr0", 32'(xch1), 32'd0); chk("u1_rr0_x", 32'(x1), 32'hA0);
    step(); chk("u1_rr1", 32'(xch1), 32'd1); chk("u1_rr1_x", 32'(x1), 32'hB1);
    step(); chk("u1_rr2", 32'(xch1), 32'd2); chk("u1_rr2_x", 32'(x1), 32'hC2);
    step(); chk("u1_wrap", 32'(xch1), 32'd0); chk("u1_wrap_x", 32'(x1), 32'hA0);
    chk("u1_wrap_valid", 32'(xv1), 32'h1);

    // fixed SEL=3 is out of range: no grant, output drains and stays empty
    mode1 = 1'b0; sel1 = 2'd3;
    #1; chk("u1_sel3_inready", 32'(ir1), 32'h0);
    step(); chk("u1_sel3_valid", 32'(xv1), 32'h0); chk("u1_sel3_hold", 32'(x1), 32'hA0);
    step(); chk("u1_sel3_valid2", 32'(xv1), 32'h0);

    // fixed grant to ch2 must not move ptr (still 1)
    sel1 = 2'd2;
    step(); chk("u1_fix2", 32'(xch1), 32'd2); chk("u1_fix2_x", 32'(x1), 32'hC2);
    mode1 = 1'b1;
    #1; chk("u1_ptr_kept_inready", 32'(ir1), 32'b010);
    step(); chk("u1_ptr_kept", 32'(xch1), 32'd1); chk("u1_ptr_kept_x", 32'(x1), 32'hB1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 2, data bits per channel.
REQ-002 SHALL have parameter NUM_CH, default 4, input channel count, legal range 2..16.
REQ-003 SHALL have derived localparam SEL_W = max(1, clog2(NUM_CH)), the select and channel-index width.
REQ-004 SHALL have port CLK, input, 1, the only clock, rising edge.
REQ-005 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-006 SHALL have port MODE, input, 1: 0 = fixed select, 1 = round-robin.
REQ-007 SHALL have port SEL, input, SEL_W, channel selected in fixed mode.
REQ-008 SHALL have port IN_DATA, input, NUM_CH*WIDTH; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port IN_VALID, input, NUM_CH, per-channel valid.
REQ-010 SHALL have port IN_READY, output, NUM_CH, per-channel accept.
REQ-011 SHALL have port X, output, WIDTH, registered selected data.
REQ-012 SHALL have port X_VALID, output, 1, X holds a beat.
REQ-013 SHALL have port X_READY, input, 1, downstream accept.
REQ-014 SHALL have port X_CH, output, SEL_W, source channel of the beat on X.

Function
REQ-015 SHALL transfer on a channel when IN_VALID[i] and IN_READY[i] are both 1 at a rising CLK edge, and on the output when X_VALID and X_READY are both 1.
REQ-016 SHALL use a one-entry output register with two states: EMPTY (X_VALID=0) and FULL (X_VALID=1).
REQ-017 SHALL assert load_en = EMPTY or (FULL and X_READY); there SHALL be no combinational path from IN_DATA to X.
REQ-018 SHALL, in fixed mode, grant channel SEL when load_en and IN_VALID[SEL] are both 1; SEL >= NUM_CH SHALL grant nothing.
REQ-019 SHALL, in round-robin mode, grant the first channel with IN_VALID=1 searching upward from ptr and wrapping NUM_CH-1 to 0.
REQ-020 SHALL drive IN_READY one-hot at the granted channel and all-zero otherwise; IN_READY SHALL depend only on the state, X_READY, MODE, SEL, ptr and IN_VALID.
REQ-021 SHALL, on a grant, register X <= channel data and X_CH <= granted index, and set FULL; latency is 1 cycle from accept to X_VALID.
REQ-022 SHALL, when X_READY=1 and there is no grant, go to EMPTY; X and X_CH SHALL then hold their last values.
REQ-023 SHALL keep X and X_CH stable while X_VALID=1 and X_READY=0.
REQ-024 SHALL, on a simultaneous output drain and new grant, stay FULL with the new beat, sustaining 1 beat/cycle.
REQ-025 SHALL advance ptr to (granted+1) mod NUM_CH only on round-robin grants; fixed-mode grants SHALL leave ptr unchanged.
REQ-026 SHALL sample MODE and SEL each cycle; a change SHALL affect only the next grant and SHALL never alter a held beat.

Reset
REQ-027 SHALL, with RST=1 at a CLK edge, set X=0, X_CH=0, X_VALID=0 (EMPTY) and ptr=0, discarding any held beat.
REQ-028 SHALL hold IN_READY all-zero in every cycle where RST=1.
REQ-029 SHALL accept traffic from the first edge after RST deasserts.

Structure
REQ-030 SHALL put the MODE encodings (MODE_FIXED=0, MODE_RR=1) and the state encodings in a shared package, stream_mux_pkg.
REQ-031 SHALL place the round-robin grant logic (request vector and ptr in; one-hot grant and index out) in sub-module rr_arbiter.
REQ-032 SHALL synthesise for NUM_CH values that are not powers of two, e.g. 3, with correct wrap.

Verification
REQ-033 SHALL check fixed mode, defaults: channels 0..3 data = 10,01,00,11, all valid, X_READY=1, SEL stepped 0..3 -> X = 10,01,00,11 one cycle later; X_CH = SEL.
REQ-034 SHALL check round-robin: all 4 channels valid continuously, X_READY=1 -> X_CH sequence 0,1,2,3,0, one beat per cycle.
REQ-035 SHALL check backpressure: X_READY=0 for 3 cycles with X_VALID=1 -> X and X_CH constant and IN_READY=0000; on release, the next beat follows with no gap.
REQ-036 SHALL check sparse round-robin: only channels 1 and 3 valid -> X_CH alternates 1,3,1; ptr skips idle channels.
REQ-037 SHALL check reset while FULL: RST pulse for 1 cycle -> X_VALID=0, X=0, X_CH=0 next cycle; the first round-robin grant after reset is to the lowest valid channel.
REQ-038 SHALL check NUM_CH=3, WIDTH=8: round-robin wraps as 2->0; fixed mode with SEL=3 -> no grant, X_VALID stays 0.
